ex_mcycle_ctrl: RTL and testbench
=================================

Name: ex_mcycle_ctrl

Overview:
Sequencer for multi-cycle EX-stage operations: two-pass MADD/MADDU/MSUB/MSUBU accumulation and handshake with the external iterative divider for DIV/DIVU. Raises the EX stall request toward ctrl and holds intermediate and final 64-bit HI/LO results across pipeline stalls. Sits beside the EX ALU, feeding the EX/MEM register's hi/lo write data. Replaces the hilo/cnt round-trip through EX/MEM.

Parameters:
DIV_W, 32, operand width; result width is 2*DIV_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  6  pipeline stall vector from ctrl; bit 3 = EX held
flush_i  in  1  synchronous cancel of the EX instruction
aluop_i  in  8  EX-stage aluop
mul_result_i  in  64  EX product, signed/unsigned per opcode
hilo_i  in  64  forwarded current {HI,LO}
op1_i  in  32  dividend
op2_i  in  32  divisor
div_result_i  in  64  {remainder,quotient} from divider
div_ready_i  in  1  divider result valid
stallreq_o  out  1  EX stall request to ctrl
res_o  out  64  final {HI,LO} for EX/MEM
res_valid_o  out  1  res_o valid this cycle
div_start_o  out  1  divider start, level-held
div_annul_o  out  1  divider cancel pulse
div_signed_o  out  1  1 = DIV, 0 = DIVU
div_op1_o  out  32  latched dividend
div_op2_o  out  32  latched divisor

Behaviour:
- Reset (async, immediate, no clock edge needed): state IDLE; all outputs 0; internal temp and result registers 0.
- States: IDLE, MACC2, DIV_WAIT, DIV_DONE.
- IDLE:
  - aluop MADD/MADDU: temp <= mul_result_i. stallreq_o = 1 combinationally. Next state MACC2.
  - aluop MSUB/MSUBU: temp <= ~mul_result_i + 1 (64-bit two's complement). stallreq_o = 1. Next state MACC2.
  - aluop DIV/DIVU: latch op1/op2 into div_op1_o/div_op2_o. div_signed_o <= (aluop==DIV). div_start_o <= 1. stallreq_o = 1. Next state DIV_WAIT.
  - Any other aluop: stallreq_o = 0, res_valid_o = 0.
- MACC2:
  - res_o = temp + hilo_i (mod 2^64, carry discarded). res_valid_o = 1. stallreq_o = 0.
  - Advance to IDLE only when stall[3] = 0.
  - Otherwise stay; res_o tracks hilo_i, which is frozen while stalled.
- DIV_WAIT:
  - stallreq_o = 1. div_start_o and the latched operands stay stable.
  - On div_ready_i: result reg <= div_result_i; div_start_o <= 0; next state DIV_DONE.
  - Divide-by-zero is resolved by the divider; the controller passes its result through.
- DIV_DONE:
  - res_o = result reg. res_valid_o = 1. stallreq_o = 0.
  - Advance to IDLE when stall[3] = 0.
- Latency: MADD/MSUB 2 EX cycles (1 stall). DIV: divider latency + 2 cycles.
- flush_i (priority over everything except rst):
  - Any state goes to IDLE next edge; div_start_o <= 0.
  - div_annul_o = 1 for that cycle, only if the state is DIV_WAIT.
  - stallreq_o = 0 in the flush cycle.
- div_ready_i outside DIV_WAIT is ignored.
- div_annul_o is 0 except in the flush case.

Decomposition:
- Aluop codes (EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP, EXE_DIV_OP, EXE_DIVU_OP), Stop/NoStop, RstEnable, ZeroWord and DoubleBus stay in define.v.
- State encodings are added to define.v as a 2-bit bus.
- No sub-module: the divider is a peer block, not instantiated here.

Test Plan:
1. MADD, mul_result_i=0x6, hilo_i=0x10:
   - cycle 1: stallreq_o=1.
   - cycle 2: stallreq_o=0, res_o=0x16, res_valid_o=1.
   - cycle 3 with stall=0: IDLE.
2. MSUB, mul_result_i=0x6, hilo_i=0x10 -> res_o=0x0A. Same op with hilo_i=0x2 -> res_o=0xFFFFFFFF_FFFFFFFC.
3. DIV, op1=0xFFFFFFF9, op2=0x2:
   - div_signed_o=1, div_start_o held, stallreq_o=1 until div_ready_i.
   - div_ready_i arrives with 0xFFFFFFFF_FFFFFFFD -> next cycle res_o=0xFFFFFFFF_FFFFFFFD, stallreq_o=0.
4. MACC2 with stall=6'b011111 for 3 cycles:
   - res_o and res_valid_o held, stallreq_o=0, state stays MACC2.
   - stall=0 -> IDLE.
5. flush_i in DIV_WAIT:
   - div_annul_o=1 for one cycle; next cycle div_start_o=0, stallreq_o=0, IDLE.
   - A late div_ready_i is ignored.
6. rst asserted mid-DIV_WAIT between clock edges -> all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/ex_mcycle_ctrl_pkg.sv
// Shared opcodes, state encoding and decode helpers
// for the EX-stage multi-cycle sequencer.
package ex_mcycle_ctrl_pkg;

  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b10101011;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int EX_STALL_BIT = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MACC2    = 2'b01,
    DIV_WAIT = 2'b10,
    DIV_DONE = 2'b11
  } mc_state_e;

  function automatic logic is_madd(
    input logic [7:0] op
  );
    return (op == EXE_MADD_OP) ||
           (op == EXE_MADDU_OP);
  endfunction

  function automatic logic is_msub(
    input logic [7:0] op
  );
    return (op == EXE_MSUB_OP) ||
           (op == EXE_MSUBU_OP);
  endfunction

  function automatic logic is_div(
    input logic [7:0] op
  );
    return (op == EXE_DIV_OP) ||
           (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_mcycle_ctrl.sv
// Multi-cycle EX sequencer: two-pass MADD/MSUB and divider handshake.
// Ports: stall/flush from ctrl, EX operands in; stallreq, {HI,LO}, divider ctl out.
module ex_mcycle_ctrl
  import ex_mcycle_ctrl_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             flush_i,
  input  logic [7:0]       aluop_i,
  input  logic [2*DIV_W-1:0] mul_result_i,
  input  logic [2*DIV_W-1:0] hilo_i,
  input  logic [DIV_W-1:0] op1_i,
  input  logic [DIV_W-1:0] op2_i,
  input  logic [2*DIV_W-1:0] div_result_i,
  input  logic             div_ready_i,
  output logic             stallreq_o,
  output logic [2*DIV_W-1:0] res_o,
  output logic             res_valid_o,
  output logic             div_start_o,
  output logic             div_annul_o,
  output logic             div_signed_o,
  output logic [DIV_W-1:0] div_op1_o,
  output logic [DIV_W-1:0] div_op2_o
);

  localparam int RW = 2 * DIV_W;

  mc_state_e state, state_n;

  logic [RW-1:0] temp;
  logic [RW-1:0] res_q;
  logic          stall_req;
  logic          ld_macc;
  logic          ld_div;
  logic          ld_res;
  logic          clr_start;
  logic          ex_held;
  logic          unused_stall;

  assign ex_held      = stall[EX_STALL_BIT];
  assign unused_stall = ^{stall[5:4], stall[2:0]};

  // Request is masked during reset so every output reads 0
  // even if a multi-cycle op is sitting on aluop_i.
  assign stallreq_o = stall_req & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    stall_req   = NO_STOP;
    res_o       = '0;
    res_valid_o = 1'b0;
    div_annul_o = 1'b0;
    ld_macc     = 1'b0;
    ld_div      = 1'b0;
    ld_res      = 1'b0;
    clr_start   = 1'b0;
    if (flush_i) begin
      state_n     = IDLE;
      clr_start   = 1'b1;
      div_annul_o = (state == DIV_WAIT);
    end else begin
      unique case (state)
        IDLE: begin
          if (is_madd(aluop_i) ||
              is_msub(aluop_i)) begin
            stall_req = STOP;
            ld_macc   = 1'b1;
            state_n   = MACC2;
          end else if (is_div(aluop_i)) begin
            stall_req = STOP;
            ld_div    = 1'b1;
            state_n   = DIV_WAIT;
          end
        end
        MACC2: begin
          res_o       = temp + hilo_i;
          res_valid_o = 1'b1;
          if (!ex_held) state_n = IDLE;
        end
        DIV_WAIT: begin
          stall_req = STOP;
          if (div_ready_i) begin
            ld_res    = 1'b1;
            clr_start = 1'b1;
            state_n   = DIV_DONE;
          end
        end
        DIV_DONE: begin
          res_o       = res_q;
          res_valid_o = 1'b1;
          if (!ex_held) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp         <= '0;
      res_q        <= '0;
      div_start_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
    end else begin
      // MSUB stores the negated product so pass 2 is a plain add.
      if (ld_macc) begin
        if (is_msub(aluop_i))
          temp <= ~mul_result_i + RW'(1);
        else
          temp <= mul_result_i;
      end
      if (ld_div) begin
        div_op1_o    <= op1_i;
        div_op2_o    <= op2_i;
        div_signed_o <= (aluop_i == EXE_DIV_OP);
        div_start_o  <= 1'b1;
      end
      if (ld_res) res_q <= div_result_i;
      if (clr_start) div_start_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mcycle_ctrl.sv
// Directed bench for ex_mcycle_ctrl with a per-cycle
// behavioural reference and literal spot checks.
module tb_ex_mcycle_ctrl;
  import ex_mcycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [63:0] mul_result_i;
  logic [63:0] hilo_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o;
  logic [63:0] res_o;
  logic        res_valid_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;

  int nvec = 0;
  int nerr = 0;

  ex_mcycle_ctrl #(.DIV_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush_i      (flush_i),
    .aluop_i      (aluop_i),
    .mul_result_i (mul_result_i),
    .hilo_i       (hilo_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .stallreq_o   (stallreq_o),
    .res_o        (res_o),
    .res_valid_o  (res_valid_o),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_op1_o    (div_op1_o),
    .div_op2_o    (div_op2_o)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // Reference: what instruction is in flight and what it
  // owes the pipeline, described as pending work.
  // pend: 0 none, 1 accumulate owed, 2 divider busy,
  // 3 quotient/remainder owed.
  int          pend;
  logic [63:0] m_prod;
  bit          m_sub;
  logic [63:0] m_dres;
  logic        m_start;
  logic        m_sgn;
  logic [31:0] m_a;
  logic [31:0] m_b;

  function automatic bit op_macc(input logic [7:0] op);
    return op == EXE_MADD_OP || op == EXE_MADDU_OP ||
           op == EXE_MSUB_OP || op == EXE_MSUBU_OP;
  endfunction

  function automatic bit op_div(input logic [7:0] op);
    return op == EXE_DIV_OP || op == EXE_DIVU_OP;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 0; m_prod = 0; m_sub = 0; m_dres = 0;
      m_start = 0; m_sgn = 0; m_a = 0; m_b = 0;
    end else if (flush_i) begin
      pend = 0;
      m_start = 0;
    end else begin
      case (pend)
        0: begin
          if (op_macc(aluop_i)) begin
            pend   = 1;
            m_prod = mul_result_i;
            m_sub  = (aluop_i == EXE_MSUB_OP) ||
                     (aluop_i == EXE_MSUBU_OP);
          end else if (op_div(aluop_i)) begin
            pend    = 2;
            m_a     = op1_i;
            m_b     = op2_i;
            m_sgn   = (aluop_i == EXE_DIV_OP);
            m_start = 1;
          end
        end
        1: if (!stall[3]) pend = 0;
        2: if (div_ready_i) begin
          m_dres  = div_result_i;
          m_start = 0;
          pend    = 3;
        end
        default: if (!stall[3]) pend = 0;
      endcase
    end
  end

  logic        e_stall;
  logic        e_valid;
  logic        e_annul;
  logic [63:0] e_res;

  always @(negedge clk) begin
    if (rst) begin
      e_stall = 0; e_valid = 0; e_annul = 0; e_res = 0;
    end else begin
      e_stall = !flush_i &&
                ((pend == 0 && (op_macc(aluop_i) ||
                  op_div(aluop_i))) || pend == 2);
      e_valid = !flush_i && (pend == 1 || pend == 3);
      e_annul = flush_i && pend == 2;
      if (!e_valid)
        e_res = 0;
      else if (pend == 1)
        e_res = m_sub ? hilo_i - m_prod
                      : hilo_i + m_prod;
      else
        e_res = m_dres;
    end
    chk("m_stallreq", 64'(stallreq_o), 64'(e_stall));
    chk("m_valid", 64'(res_valid_o), 64'(e_valid));
    chk("m_res", res_o, e_res);
    chk("m_annul", 64'(div_annul_o), 64'(e_annul));
    chk("m_start", 64'(div_start_o), 64'(m_start));
    chk("m_signed", 64'(div_signed_o), 64'(m_sgn));
    chk("m_op1", 64'(div_op1_o), 64'(m_a));
    chk("m_op2", 64'(div_op2_o), 64'(m_b));
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; stall = 0; flush_i = 0;
    aluop_i = EXE_NOP_OP; mul_result_i = 0;
    hilo_i = 0; op1_i = 0; op2_i = 0;
    div_result_i = 0; div_ready_i = 0;
    #2;
    chk("rst_stallreq", 64'(stallreq_o), 0);
    chk("rst_res", res_o, 0);
    chk("rst_start", 64'(div_start_o), 0);
    nxt(); rst = 0;

    // MADD 6 + 0x10
    aluop_i = EXE_MADD_OP; mul_result_i = 64'h6;
    hilo_i = 64'h10;
    smp(); chk("t1_c1_stall", 64'(stallreq_o), 1);
    nxt(); aluop_i = EXE_NOP_OP;
    smp();
    chk("t1_c2_stall", 64'(stallreq_o), 0);
    chk("t1_c2_res", res_o, 64'h16);
    chk("t1_c2_valid", 64'(res_valid_o), 1);
    nxt();
    smp(); chk("t1_c3_idle", 64'(res_valid_o), 0);

    // MSUB 0x10 - 6
    nxt(); aluop_i = EXE_MSUB_OP;
    smp();
    nxt(); aluop_i = EXE_NOP_OP;
    smp(); chk("t2a_res", res_o, 64'h0A);
    // MSUBU 0x2 - 6 wraps
    nxt(); aluop_i = EXE_MSUBU_OP; hilo_i = 64'h2;
    smp();
    nxt(); aluop_i = EXE_NOP_OP;
    smp();
    chk("t2b_res", res_o, 64'hFFFFFFFF_FFFFFFFC);
    nxt();

    // signed DIV -7 / 2
    aluop_i = EXE_DIV_OP;
    op1_i = 32'hFFFFFFF9; op2_i = 32'h2;
    smp(); chk("t3_c1_stall", 64'(stallreq_o), 1);
    nxt(); aluop_i = EXE_NOP_OP; op1_i = 0; op2_i = 0;
    smp();
    chk("t3_signed", 64'(div_signed_o), 1);
    chk("t3_start", 64'(div_start_o), 1);
    chk("t3_op1", 64'(div_op1_o), 64'hFFFFFFF9);
    nxt();
    smp(); chk("t3_wait_stall", 64'(stallreq_o), 1);
    nxt();
    div_ready_i = 1;
    div_result_i = 64'hFFFFFFFF_FFFFFFFD;
    smp(); chk("t3_rdy_stall", 64'(stallreq_o), 1);
    nxt(); div_ready_i = 0; div_result_i = 0;
    smp();
    chk("t3_res", res_o, 64'hFFFFFFFF_FFFFFFFD);
    chk("t3_done_stall", 64'(stallreq_o), 0);
    chk("t3_done_start", 64'(div_start_o), 0);
    nxt();

    // MADD held three cycles by a downstream stall
    aluop_i = EXE_MADD_OP; mul_result_i = 64'h3;
    hilo_i = 64'h5;
    smp();
    for (int i = 0; i < 3; i++) begin
      nxt(); aluop_i = EXE_NOP_OP; stall = 6'b011111;
      smp();
      chk("t4_hold_res", res_o, 64'h8);
      chk("t4_hold_valid", 64'(res_valid_o), 1);
      chk("t4_hold_stall", 64'(stallreq_o), 0);
    end
    nxt(); stall = 0;
    smp(); chk("t4_rel_valid", 64'(res_valid_o), 1);
    nxt();
    smp(); chk("t4_idle", 64'(res_valid_o), 0);

    // DIVU cancelled by flush, late ready ignored
    nxt(); aluop_i = EXE_DIVU_OP;
    op1_i = 32'd100; op2_i = 32'd7;
    smp();
    nxt(); aluop_i = EXE_NOP_OP;
    smp(); chk("t5_signed", 64'(div_signed_o), 0);
    nxt(); flush_i = 1;
    smp();
    chk("t5_annul", 64'(div_annul_o), 1);
    chk("t5_fl_stall", 64'(stallreq_o), 0);
    nxt(); flush_i = 0; div_ready_i = 1;
    div_result_i = 64'h2_0000000E;
    smp();
    chk("t5_annul_gone", 64'(div_annul_o), 0);
    chk("t5_start", 64'(div_start_o), 0);
    chk("t5_stall", 64'(stallreq_o), 0);
    nxt(); div_ready_i = 0;
    smp(); chk("t5_late", 64'(res_valid_o), 0);

    // DIVU by zero: result passes straight through
    nxt(); aluop_i = EXE_DIVU_OP;
    op1_i = 32'h1234; op2_i = 32'h0;
    nxt(); aluop_i = EXE_NOP_OP;
    div_ready_i = 1;
    div_result_i = 64'h00001234_FFFFFFFF;
    nxt(); div_ready_i = 0;
    smp();
    chk("t7_res", res_o, 64'h00001234_FFFFFFFF);
    nxt();

    // async reset in the middle of a divide
    aluop_i = EXE_DIV_OP;
    op1_i = 32'h55; op2_i = 32'h3;
    nxt(); aluop_i = EXE_DIV_OP;
    #3 rst = 1;
    #1;
    chk("t6_stall", 64'(stallreq_o), 0);
    chk("t6_start", 64'(div_start_o), 0);
    chk("t6_signed", 64'(div_signed_o), 0);
    chk("t6_op1", 64'(div_op1_o), 0);
    chk("t6_valid", 64'(res_valid_o), 0);
    aluop_i = EXE_NOP_OP;
    nxt(); rst = 0;
    smp();
    chk("t6_idle_stall", 64'(stallreq_o), 0);
    chk("t6_idle_valid", 64'(res_valid_o), 0);
    nxt();
    smp();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
